// File: rtl/nic_mem.sv
// nic_mem: clocked RAM for the nic8 CPU with post-reset clear, byte-serial loader,
// wait-stated request/ready access port and a memory-mapped output register.
module nic_mem #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                WAIT     = 0,
    parameter logic [ADDR_W-1:0] OUT_ADDR = {ADDR_W{1'b1}}
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_load,
    input  logic              i_store,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    input  logic              i_ld_valid,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_ld_last,
    output logic              o_ld_ready,
    output logic              o_running,
    output logic              o_out_valid,
    output logic [DATA_W-1:0] o_out_data
);

    // state  | meaning
    // S_CLEAR| zero every address from ptr 0 up to the top, CPU held off
    // S_LOAD | accept loader words into ram[ptr], CPU held off
    // S_IDLE | running, waiting for a CPU load/store request
    // S_BUSY | running, counting wait states before completing the access
    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_IDLE  = 2'd2,
        S_BUSY  = 2'd3
    } state_t;

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT);

    logic [DATA_W-1:0] r_ram [DEPTH];

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_store;

    logic              w_done;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_done = (r_state == S_BUSY) && (r_cnt == 4'd0);

    // Single RAM write port shared by clear, loader and CPU stores; reset blocks all writes.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_ptr;
        w_wdata = '0;
        if (!i_reset) begin
            case (r_state)
                S_CLEAR: w_we = 1'b1;
                S_LOAD: begin
                    w_we    = i_ld_valid;
                    w_wdata = i_ld_data;
                end
                S_BUSY: begin
                    w_we    = w_done && r_is_store;
                    w_waddr = r_addr;
                    w_wdata = r_wdata;
                end
                default: w_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_ram[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_CLEAR;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_store  <= 1'b0;
            o_rdata     <= '0;
            o_ready     <= 1'b0;
            o_ld_ready  <= 1'b0;
            o_running   <= 1'b0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
        end else begin
            o_ready     <= 1'b0;
            o_out_valid <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == LAST_ADDR) begin
                        r_state    <= S_LOAD;
                        o_ld_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (i_ld_valid) begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                        // a word landing on the top address fills memory and ends loading
                        if (i_ld_last || (r_ptr == LAST_ADDR)) begin
                            r_state    <= S_IDLE;
                            o_ld_ready <= 1'b0;
                            o_running  <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (i_store) begin
                        r_addr     <= i_addr;
                        r_wdata    <= i_wdata;
                        r_is_store <= 1'b1;
                        r_cnt      <= WAIT_INIT;
                        r_state    <= S_BUSY;
                    end else if (i_load) begin
                        r_addr     <= i_addr;
                        r_is_store <= 1'b0;
                        r_cnt      <= WAIT_INIT;
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_IDLE;
                        o_ready <= 1'b1;
                        if (r_is_store) begin
                            if (r_addr == OUT_ADDR) begin
                                o_out_valid <= 1'b1;
                                o_out_data  <= r_wdata;
                            end
                        end else begin
                            o_rdata <= r_ram[r_addr];
                        end
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: doc/nic_mem.md
# nic_mem

Parametrised memory subsystem for the nic8 CPU. It replaces the bare `ram` array and its async read with a clocked memory. It also adds:
- a sequential clear after reset;
- a byte-serial program loader, so no `$readmemh` is needed;
- a request/ready access port with configurable wait states;
- a memory-mapped output port.

It sits between the CPU abus/dbus and the storage, and holds the CPU off until the program is loaded.

## Interface
Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- WAIT, 0, extra wait cycles per CPU access (0..15).
- OUT_ADDR, 2**ADDR_W-1, address whose stores are also sent to the output port.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- addr  in  ADDR_W  CPU access address.
- wdata  in  DATA_W  CPU store data.
- load  in  1  CPU read request.
- store  in  1  CPU write request.
- rdata  out  DATA_W  read data, valid while ready=1 after a load.
- ready  out  1  one-cycle pulse marking access completion.
- ld_valid  in  1  loader word present.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  marks the final loader word.
- ld_ready  out  1  loader accepts a word this cycle.
- running  out  1  CPU may issue accesses.
- out_valid  out  1  one-cycle pulse: a store to OUT_ADDR completed.
- out_data  out  DATA_W  last value stored to OUT_ADDR.

## Operation
States: CLEAR, LOAD, IDLE, BUSY. A reset-mid-operation rule overrides all of them.

CLEAR:
- Entered on reset.
- Writes 0 to ram[ptr] and increments ptr each cycle, from 0 to 2**ADDR_W-1.
- Moves to LOAD after writing the last address; ptr wraps to 0.

LOAD:
- ld_ready=1.
- Each cycle with ld_valid=1 writes ld_data to ram[ptr] and increments ptr.
- Moves to IDLE if the accepted word has ld_last=1.
- Also moves to IDLE if the word was written at the last address (memory full), whatever ld_last is.
- ld_valid=0 stalls; no write occurs.

IDLE (running=1):
- If store=1, latch addr/wdata, counter=WAIT, go to BUSY. A store is accepted even if load=1 (store has priority; the load is dropped).
- Otherwise, if load=1, latch addr, counter=WAIT, go to BUSY.

BUSY (running=1):
- Decrements the counter each cycle while it is nonzero.
- In the cycle when the counter is 0, it completes the access and returns to IDLE:
  - Load: rdata <= ram[latched addr].
  - Store: ram[latched addr] <= latched wdata.
  - Store to OUT_ADDR: additionally out_data <= wdata and out_valid pulses. RAM is written as well.
- ready pulses for exactly one cycle, registered together with rdata.
- load/store inputs are ignored while in BUSY.
- The CPU must hold load/store low during the ready cycle if it does not intend a new access. A request still high in the ready cycle is sampled in the next IDLE cycle.

Reset mid-operation:
- Discards any in-flight access; no write occurs.
- Returns to CLEAR with ptr=0.
- RAM contents are then re-zeroed by CLEAR.

Other rules:
- rdata holds its last value between loads.
- out_data holds until the next OUT_ADDR store.
- All arithmetic is modulo 2**ADDR_W on ptr; there are no other widths.

## Timing
Output values in the cycle after reset is asserted, held while it stays asserted:
- ready=0, rdata=0, ld_ready=0, running=0, out_valid=0, out_data=0.

CLEAR:
- Occupies exactly 2**ADDR_W cycles after reset deasserts.
- ld_ready rises in the following cycle.

LOAD:
- Zero-bubble: one word accepted per cycle while ld_valid=1.

Switch to running:
- running rises the cycle after the terminating loader word is accepted.

CPU access latency:
- A request sampled in IDLE at edge N produces ready=1 in cycle N+1+WAIT.
- The next request can be sampled at edge N+2+WAIT.
- Peak throughput: one access per 2+WAIT cycles.

Store visibility:
- A store is visible to a load accepted at or after its ready edge.
- out_valid coincides with ready for OUT_ADDR stores.

## Test plan
- Reset then clear (ADDR_W=4): after reset deasserts, 16 cycles pass with ld_ready=0; ld_ready=1 in cycle 17. Loading a single word with ld_last=1 then lets reads of addr 1..15 return 0.
- Load then read (WAIT=0): load 0x3A,0x5C,0x7F with ld_last on the third word; running rises next cycle. A load at addr 2 gives ready one cycle later with rdata=0x7F.
- Wait states (WAIT=3): a store of 0xAA to addr 5 gives ready exactly 4 cycles after acceptance. A load of addr 5 that follows returns 0xAA after 4 cycles. load/store toggled during BUSY has no effect.
- Output port: a store of 0x42 to OUT_ADDR (0xFF) pulses out_valid for one cycle with out_data=0x42. A later load of 0xFF returns 0x42. A store to 0xFE does not pulse out_valid.
- Boundaries:
  - Loader full: in LOAD with ADDR_W=4, 16 words with ld_last=0 give running=1 after the 16th word and ld_ready=0 thereafter.
  - Simultaneous load+store to addr 3 with wdata 0x11: the store is performed, and a following load of 3 returns 0x11.
- Reset mid-access: assert reset during BUSY of a store of 0x99 to addr 7. Outputs take their reset values. After re-clear and a minimal load, addr 7 reads 0, not 0x99.
